// File: rtl/ofdm_rx_pkg.sv
// Shared types, sizing constants and the burst level function for the OFDM receive path.
package ofdm_rx_pkg;

  localparam int sample_bit_width_c  = 12;
  localparam int symbol_length_c     = 160;
  localparam int raw_symbol_length_c = 128;
  localparam int osr_c               = 10;
  localparam int cp_length_c         = symbol_length_c - raw_symbol_length_c;

  typedef enum logic [1:0] {
    IDLE,
    CP,
    DATA
  } state_t;

  // One extra bit so that |most negative| and the sum of two magnitudes never overflow.
  function automatic logic [sample_bit_width_c:0] abs_sum(
    input logic signed [sample_bit_width_c-1:0] i,
    input logic signed [sample_bit_width_c-1:0] q
  );
    logic signed [sample_bit_width_c:0] ie;
    logic signed [sample_bit_width_c:0] qe;
    logic        [sample_bit_width_c:0] ai;
    logic        [sample_bit_width_c:0] aq;
    ie = i;
    qe = q;
    ai = ie[sample_bit_width_c] ? $unsigned(-ie) : $unsigned(ie);
    aq = qe[sample_bit_width_c] ? $unsigned(-qe) : $unsigned(qe);
    return ai + aq;
  endfunction

endpackage

// File: rtl/ofdm_rx_decimator.sv
// Keeps the first of every osr_c valid input samples and presents it one cycle later.
module ofdm_rx_decimator
  import ofdm_rx_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init,
  input  logic [sample_bit_width_c-1:0] in_i,
  input  logic [sample_bit_width_c-1:0] in_q,
  input  logic                          in_vld,
  output logic [sample_bit_width_c-1:0] i_p0,
  output logic [sample_bit_width_c-1:0] q_p0,
  output logic                          vld_p0
);

  localparam int cnt_w_c = (osr_c > 1) ? $clog2(osr_c) : 1;
  localparam logic [cnt_w_c-1:0] cnt_last_c = cnt_w_c'(osr_c - 1);

  logic [cnt_w_c-1:0] cnt;
  logic               keep;

  assign keep = in_vld && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      vld_p0 <= 1'b0;
    end else if (init) begin
      cnt    <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= keep;
      if (in_vld) begin
        cnt <= (cnt == cnt_last_c) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Stage p0: kept sample, qualified by vld_p0.
  always_ff @(posedge clk) begin
    if (keep) begin
      i_p0 <= in_i;
      q_p0 <= in_q;
    end
  end

endmodule

// File: rtl/ofdm_rx.sv
// OFDM receive path: decimation, burst detection, symbol framing, CP removal and QPSK hard decisions.
// Optional macro OFDM_RX_SYM_COUNT_EN adds a saturating per-burst symbol counter output.
module ofdm_rx
  import ofdm_rx_pkg::*;
(
  input  logic                          sys_clk,
  input  logic                          sys_rstn,
  input  logic                          sys_init,
  input  logic [sample_bit_width_c-1:0] min_level,
  input  logic [sample_bit_width_c-1:0] rx_data_i,
  input  logic [sample_bit_width_c-1:0] rx_data_q,
  input  logic                          rx_data_valid,
  output logic [1:0]                    rx_rcv_data,
  output logic                          rx_rcv_data_valid,
  output logic                          rx_rcv_data_start
`ifdef OFDM_RX_SYM_COUNT_EN
  ,
  output logic [15:0]                   rx_symbol_count
`endif
);

  localparam int w_c     = sample_bit_width_c;
  localparam int idx_w_c = $clog2(symbol_length_c);
  localparam logic [idx_w_c-1:0] cp_last_c  = idx_w_c'(cp_length_c - 1);
  localparam logic [idx_w_c-1:0] cp_first_c = idx_w_c'(cp_length_c);
  localparam logic [idx_w_c-1:0] sym_last_c = idx_w_c'(symbol_length_c - 1);

  logic [w_c-1:0]        dec_i_p0;
  logic [w_c-1:0]        dec_q_p0;
  logic                  vld_p0;
  logic signed [w_c-1:0] si_p0;
  logic signed [w_c-1:0] sq_p0;
  logic [w_c:0]          level_p0;
  logic [w_c:0]          thresh;
  logic [w_c:0]          peak_max;

  state_t               state, state_n;
  logic [idx_w_c-1:0]   idx, idx_n;
  logic [w_c:0]         peak, peak_n;
  logic [1:0]           data_n;
  logic                 vld_n;
  logic                 start_n;

  ofdm_rx_decimator u_decimator (
    .clk    (sys_clk),
    .rst_n  (sys_rstn),
    .init   (sys_init),
    .in_i   (rx_data_i),
    .in_q   (rx_data_q),
    .in_vld (rx_data_valid),
    .i_p0   (dec_i_p0),
    .q_p0   (dec_q_p0),
    .vld_p0 (vld_p0)
  );

  assign si_p0    = dec_i_p0;
  assign sq_p0    = dec_q_p0;
  assign level_p0 = abs_sum(si_p0, sq_p0);
  assign thresh   = {1'b0, min_level};
  assign peak_max = (level_p0 > peak) ? level_p0 : peak;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    peak_n  = peak;
    data_n  = rx_rcv_data;
    vld_n   = 1'b0;
    start_n = 1'b0;
    if (vld_p0) begin
      case (state)
        IDLE: begin
          if (level_p0 >= thresh) begin
            state_n = CP;
            idx_n   = idx_w_c'(1);
            peak_n  = level_p0;
          end
        end
        CP: begin
          peak_n = peak_max;
          idx_n  = idx + 1'b1;
          if (idx == cp_last_c) state_n = DATA;
        end
        DATA: begin
          vld_n   = 1'b1;
          start_n = (idx == cp_first_c);
          data_n  = {si_p0[w_c-1], sq_p0[w_c-1]};
          if (idx == sym_last_c) begin
            // Burst continues only if something in this symbol reached the threshold.
            idx_n   = '0;
            peak_n  = '0;
            state_n = (peak_max >= thresh) ? CP : IDLE;
          end else begin
            idx_n  = idx + 1'b1;
            peak_n = peak_max;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p1: framing state and registered hard decisions.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state             <= IDLE;
      idx               <= '0;
      peak              <= '0;
      rx_rcv_data       <= '0;
      rx_rcv_data_valid <= 1'b0;
      rx_rcv_data_start <= 1'b0;
    end else if (sys_init) begin
      state             <= IDLE;
      idx               <= '0;
      peak              <= '0;
      rx_rcv_data       <= '0;
      rx_rcv_data_valid <= 1'b0;
      rx_rcv_data_start <= 1'b0;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      peak              <= peak_n;
      rx_rcv_data       <= data_n;
      rx_rcv_data_valid <= vld_n;
      rx_rcv_data_start <= start_n;
    end
  end

`ifdef OFDM_RX_SYM_COUNT_EN
  logic last_data;
  logic enter_idle;

  assign last_data  = vld_p0 && (state == DATA) && (idx == sym_last_c);
  assign enter_idle = (state != IDLE) && (state_n == IDLE);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_symbol_count <= '0;
    end else if (sys_init || enter_idle) begin
      rx_symbol_count <= '0;
    end else if (last_data && (rx_symbol_count != 16'hFFFF)) begin
      rx_symbol_count <= rx_symbol_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_rx.sv
// Directed and randomized bench for ofdm_rx against a sample-level framing model.
module tb_ofdm_rx;

  localparam int OSR = 10;
  localparam int SYM = 160;
  localparam int CPL = 32;

  logic        sys_clk = 1'b0;
  logic        sys_rstn;
  logic        sys_init;
  logic [11:0] min_level;
  logic [11:0] rx_data_i;
  logic [11:0] rx_data_q;
  logic        rx_data_valid;
  logic [1:0]  rx_rcv_data;
  logic        rx_rcv_data_valid;
  logic        rx_rcv_data_start;

  ofdm_rx dut (
    .sys_clk           (sys_clk),
    .sys_rstn          (sys_rstn),
    .sys_init          (sys_init),
    .min_level         (min_level),
    .rx_data_i         (rx_data_i),
    .rx_data_q         (rx_data_q),
    .rx_data_valid     (rx_data_valid),
    .rx_rcv_data       (rx_rcv_data),
    .rx_rcv_data_valid (rx_rcv_data_valid),
    .rx_rcv_data_start (rx_rcv_data_start)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: valid-input count, pending kept sample, burst position and peak.
  int         vcount;
  bit         pend_v;
  int         pend_i, pend_q;
  bit         active;
  int         pos, peak;
  bit         exp_vld, exp_start;
  logic [1:0] exp_data;

  // Per-segment observations.
  int         seg_k, n_out, n_start, first_start, second_start, last_vld, prev_vld;
  logic [1:0] start_data;
  logic [1:0] qd [4];

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    assert (act === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp_v);
    end
  endtask

  task automatic model_clear();
    vcount = 0; pend_v = 0; pend_i = 0; pend_q = 0;
    active = 0; pos = 0; peak = 0;
    exp_vld = 0; exp_start = 0; exp_data = 2'b00;
  endtask

  task automatic frame(input int i, input int q);
    int lv;
    lv = iabs(i) + iabs(q);
    if (!active) begin
      if (lv >= int'(min_level)) begin
        active = 1; pos = 1; peak = lv;
      end
    end else begin
      if (lv > peak) peak = lv;
      if (pos >= CPL) begin
        exp_vld   = 1;
        exp_start = (pos == CPL);
        exp_data  = {i < 0, q < 0};
      end
      pos++;
      if (pos == SYM) begin
        pos = 0;
        if (peak < int'(min_level)) active = 0;
        peak = 0;
      end
    end
  endtask

  task automatic seg_reset();
    seg_k = 0; n_out = 0; n_start = 0;
    first_start = -1; second_start = -1; last_vld = -1; prev_vld = -1;
    start_data = 2'b00;
    for (int j = 0; j < 4; j++) qd[j] = 2'b00;
  endtask

  task automatic step(input bit v, input int i, input int q, input bit init = 1'b0);
    rx_data_valid = v;
    rx_data_i     = 12'(i);
    rx_data_q     = 12'(q);
    sys_init      = init;
    @(posedge sys_clk);
    if (init) begin
      model_clear();
    end else begin
      exp_vld = 0; exp_start = 0;
      if (pend_v) frame(pend_i, pend_q);
      pend_v = v && (vcount == 0);
      if (pend_v) begin pend_i = i; pend_q = q; end
      if (v) vcount = (vcount + 1) % OSR;
    end
    #1;
    check("valid", 32'(rx_rcv_data_valid), 32'(exp_vld));
    check("start", 32'(rx_rcv_data_start), 32'(exp_start));
    check("data",  32'(rx_rcv_data),       32'(exp_data));
    if (rx_rcv_data_valid === 1'b1) begin
      if (n_out < 4) qd[n_out] = rx_rcv_data;
      n_out++;
      prev_vld = last_vld;
      last_vld = seg_k + 1;
    end
    if (rx_rcv_data_start === 1'b1) begin
      n_start++;
      if (n_start == 1) begin first_start = seg_k + 1; start_data = rx_rcv_data; end
      if (n_start == 2) second_start = seg_k + 1;
    end
    seg_k++;
  endtask

  task automatic run_const(input int n, input int i, input int q, input int gap = 1);
    for (int k = 0; k < n; k++) step((k % gap) == 0, i, q);
  endtask

  task automatic async_reset();
    sys_rstn = 1'b0;
    #1;
    model_clear();
    check("arst_valid", 32'(rx_rcv_data_valid), 32'd0);
    check("arst_start", 32'(rx_rcv_data_start), 32'd0);
    check("arst_data",  32'(rx_rcv_data),       32'd0);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(0, 49));
    if (r == 0) return -2048;
    if (r == 1) return 0;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin
    sys_rstn = 1'b0; sys_init = 1'b0; rx_data_valid = 1'b0;
    rx_data_i = '0; rx_data_q = '0; min_level = 12'd50;
    model_clear();
    #1;
    check("rst_valid", 32'(rx_rcv_data_valid), 32'd0);
    check("rst_start", 32'(rx_rcv_data_start), 32'd0);
    check("rst_data",  32'(rx_rcv_data),       32'd0);
    @(negedge sys_clk);
    sys_rstn = 1'b1;

    // Continuous burst at level 200, threshold 50.
    seg_reset();
    run_const(3300, 100, -100);
    check("t1_first_start", first_start, 322);
    check("t1_start_data", 32'(start_data), 32'd1);
    check("t1_second_start", second_start, 1922);
    check("t1_spacing", last_vld - prev_vld, 10);
    check("t1_count", n_out, 256);

    // Threshold above the signal level.
    step(0, 0, 0, 1'b1);
    min_level = 12'd300;
    seg_reset();
    run_const(2000, 100, -100);
    check("t2_count", n_out, 0);

    // One loud symbol then silence; the detection sample keeps the second symbol alive.
    step(0, 0, 0, 1'b1);
    min_level = 12'd50;
    seg_reset();
    run_const(1600, 100, -100);
    run_const(3200, 0, 0);
    check("t3_count", n_out, 256);
    seg_reset();
    run_const(1000, 100, -100);
    check("t3_redetect_start", first_start, 322);

    // Quadrant sweep inside DATA.
    step(0, 0, 0, 1'b1);
    seg_reset();
    run_const(320, 100, -100);
    for (int r = 0; r < 32; r++) begin
      run_const(10, 5, 5);
      run_const(10, -5, 5);
      run_const(10, 5, -5);
      run_const(10, -5, -5);
    end
    check("t4_q0", 32'(qd[0]), 32'd0);
    check("t4_q1", 32'(qd[1]), 32'd2);
    check("t4_q2", 32'(qd[2]), 32'd1);
    check("t4_q3", 32'(qd[3]), 32'd3);

    // sys_init in the middle of DATA.
    step(0, 0, 0, 1'b1);
    seg_reset();
    run_const(500, 100, -100);
    step(1, 100, -100, 1'b1);
    check("t5_init_valid", 32'(rx_rcv_data_valid), 32'd0);
    check("t5_init_data",  32'(rx_rcv_data),       32'd0);
    seg_reset();
    run_const(500, 100, -100);
    check("t5_redetect_start", first_start, 322);

    // Asynchronous reset in the middle of DATA.
    async_reset();
    seg_reset();
    run_const(500, 100, -100);
    check("t6_redetect_start", first_start, 322);

    // Valid on every third cycle.
    step(0, 0, 0, 1'b1);
    seg_reset();
    run_const(1400, 100, -100, 3);
    check("t7_first_start", first_start, 962);
    check("t7_spacing", last_vld - prev_vld, 30);

    // Randomized samples, gaps and thresholds.
    step(0, 0, 0, 1'b1);
    seg_reset();
    for (int b = 0; b < 8; b++) begin
      min_level = (b == 3) ? 12'd0 : 12'($urandom_range(100, 450));
      if (b == 5) step(0, 0, 0, 1'b1);
      for (int k = 0; k < 2500; k++) begin
        step($urandom_range(0, 3) != 0, rnd_sample(), rnd_sample());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
